cmd_route_ctrl: RTL and testbench

CMD_ROUTE_CTRL -- requirements
Module: cmd_route_ctrl

---
 rtl/cmdctrl_pkg.sv | 18 +
 rtl/route_fifo.sv | 58 +++++
 rtl/cmd_route_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_cmd_route_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmdctrl_pkg.sv
// Shared types and opcode encodings for the command routing controller.
package cmdctrl_pkg;

    // Controller states: wait for a command, decode it, travel, check a station ID.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD_CHK = 2'd1,
        MOVING  = 2'd2,
        ID_CHK  = 2'd3
    } state_t;

    // Opcode field of the command byte.
    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_GO     = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

endpackage : cmdctrl_pkg

// File: rtl/route_fifo.sv
// Waypoint queue: a small FIFO with wrapping pointers, single-cycle flush and
// a registered occupancy count. Push and pop are never requested together.
module route_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    // Write the pushed waypoint into the slot at the write pointer.
    // NOTE: storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and count bookkeeping; flush returns everything to empty at once.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (push && !full) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_cnt    <= r_cnt + CNT_W'(1);
        end else if (pop && (r_cnt != '0)) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    assign head = r_mem[r_rd_ptr];
    assign cnt  = r_cnt;
    assign full = (r_cnt == CNT_W'(DEPTH));

endmodule : route_fifo

// File: rtl/cmd_route_ctrl.sv
// Command routing controller: consumes GO/STOP/APPEND commands, tracks the
// current destination plus a queue of waypoints, and advances on station IDs.
// Optional watchdog: define CMDCTRL_TIMEOUT_EN to abandon a trip that sees no
// station for TIMEOUT_CYC cycles and to add the one-cycle timeout output.
module cmd_route_ctrl
    import cmdctrl_pkg::*;
#(
    parameter int ID_W        = 6,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_rdy,
    input  logic [ID_W+1:0]            cmd,
    input  logic                       ID_vld,
    input  logic [ID_W-1:0]            ID,
    output logic                       clr_cmd_rdy,
    output logic                       clr_ID_vld,
    output logic                       in_transit,
    output logic [ID_W-1:0]            dest_ID,
    output logic                       arrived,
    output logic [$clog2(DEPTH+1)-1:0] q_cnt,
    output logic                       q_ovf
`ifdef CMDCTRL_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    state_t            r_state;
    logic              r_clr_cmd_rdy;
    logic              r_clr_ID_vld;
    logic              r_in_transit;
    logic [ID_W-1:0]   r_dest_ID;
    logic              r_arrived;
    logic              r_q_ovf;

    logic [1:0]        w_op;
    logic [ID_W-1:0]   w_cmd_id;
    logic              w_id_match;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [ID_W-1:0]   w_fifo_head;
    logic [CNT_W-1:0]  w_fifo_cnt;
    logic              w_fifo_full;
    logic              w_tmo_hit;

    assign w_op       = cmd[ID_W+1:ID_W];
    assign w_cmd_id   = cmd[ID_W-1:0];
    assign w_id_match = (ID == r_dest_ID);

`ifdef CMDCTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC+1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    // Watchdog: counts cycles spent in MOVING, cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == MOVING) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = (r_state == MOVING) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout   = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Queue control strobes decoded from the current state and inputs.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_flush = w_tmo_hit;
        if (r_state == CMD_CHK) begin
            w_push  = (w_op == OP_APPEND) && r_in_transit && !w_fifo_full;
            w_flush = (w_op == OP_GO) || (w_op == OP_STOP);
        end else if (r_state == ID_CHK) begin
            w_pop   = w_id_match && (w_fifo_cnt != '0);
        end
    end

    route_fifo #(
        .W     (ID_W),
        .DEPTH (DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_cmd_id),
        .head  (w_fifo_head),
        .cnt   (w_fifo_cnt),
        .full  (w_fifo_full)
    );

    // Main controller FSM with registered strobes, pulses and route status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_clr_cmd_rdy <= 1'b0;
            r_clr_ID_vld  <= 1'b0;
            r_in_transit  <= 1'b0;
            r_dest_ID     <= '0;
            r_arrived     <= 1'b0;
            r_q_ovf       <= 1'b0;
`ifdef CMDCTRL_TIMEOUT_EN
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_clr_cmd_rdy <= 1'b0;
            r_clr_ID_vld  <= 1'b0;
            r_arrived     <= 1'b0;
            r_q_ovf       <= 1'b0;
`ifdef CMDCTRL_TIMEOUT_EN
            r_timeout     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cmd_rdy) begin
                        r_state       <= CMD_CHK;
                        r_clr_cmd_rdy <= 1'b1;
                    end
                end
                MOVING: begin
                    if (w_tmo_hit) begin
                        r_state      <= IDLE;
                        r_in_transit <= 1'b0;
`ifdef CMDCTRL_TIMEOUT_EN
                        r_timeout    <= 1'b1;
`endif
                    end else if (ID_vld) begin
                        r_state      <= ID_CHK;
                        r_clr_ID_vld <= 1'b1;
                    end else if (cmd_rdy) begin
                        r_state       <= CMD_CHK;
                        r_clr_cmd_rdy <= 1'b1;
                    end
                end
                CMD_CHK: begin
                    case (w_op)
                        OP_GO: begin
                            r_dest_ID    <= w_cmd_id;
                            r_in_transit <= 1'b1;
                            r_state      <= MOVING;
                        end
                        OP_STOP: begin
                            r_in_transit <= 1'b0;
                            r_state      <= IDLE;
                        end
                        OP_APPEND: begin
                            if (r_in_transit) begin
                                r_q_ovf <= w_fifo_full;
                            end else begin
                                // Nothing to queue behind: start travelling to it directly.
                                r_dest_ID    <= w_cmd_id;
                                r_in_transit <= 1'b1;
                            end
                            r_state <= MOVING;
                        end
                        default: begin
                            r_state <= r_in_transit ? MOVING : IDLE;
                        end
                    endcase
                end
                ID_CHK: begin
                    if (w_id_match) begin
                        r_arrived <= 1'b1;
                        if (w_fifo_cnt != '0) begin
                            r_dest_ID <= w_fifo_head;
                            r_state   <= MOVING;
                        end else begin
                            r_in_transit <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end else begin
                        r_state <= MOVING;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign clr_cmd_rdy = r_clr_cmd_rdy;
    assign clr_ID_vld  = r_clr_ID_vld;
    assign in_transit  = r_in_transit;
    assign dest_ID     = r_dest_ID;
    assign arrived     = r_arrived;
    assign q_ovf       = r_q_ovf;
    assign q_cnt       = w_fifo_cnt;

endmodule : cmd_route_ctrl

// File: tb/tb_cmd_route_ctrl.sv
// Self-checking bench for cmd_route_ctrl: a queue-based route model compared
// against the DUT on every falling edge, plus directed literal expectations.
module tb_cmd_route_ctrl;

    localparam int ID_W  = 6;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int TMO   = 16;
    localparam int LIMIT = 20;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] GO   = 2'b01;
    localparam logic [1:0] APP  = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             cmd_rdy = 1'b0;
    logic [ID_W+1:0]  cmd     = '0;
    logic             ID_vld  = 1'b0;
    logic [ID_W-1:0]  ID      = '0;
    logic             clr_cmd_rdy;
    logic             clr_ID_vld;
    logic             in_transit;
    logic [ID_W-1:0]  dest_ID;
    logic             arrived;
    logic [CNT_W-1:0] q_cnt;
    logic             q_ovf;
`ifdef CMDCTRL_TIMEOUT_EN
    logic             timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cmd_route_ctrl #(
        .ID_W        (ID_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .ID_vld      (ID_vld),
        .ID          (ID),
        .clr_cmd_rdy (clr_cmd_rdy),
        .clr_ID_vld  (clr_ID_vld),
        .in_transit  (in_transit),
        .dest_ID     (dest_ID),
        .arrived     (arrived),
        .q_cnt       (q_cnt),
        .q_ovf       (q_ovf)
`ifdef CMDCTRL_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no strobe within %0d cycles at %0t", name, LIMIT, $time);
    endtask

    // ---------------- route model ----------------
    // A check cycle is exactly the cycle whose consume strobe is high; outside
    // check cycles the controller is travelling iff a trip is in progress.
    bit              m_clr_cmd = 0;
    bit              m_clr_id  = 0;
    bit              m_in      = 0;
    bit              m_arr     = 0;
    bit              m_ovf     = 0;
    bit              m_tmo_p   = 0;
    logic [ID_W-1:0] m_dest    = '0;
    logic [ID_W-1:0] m_q [$];
    int              m_tmo     = 0;
    bit              do_cmd;
    bit              do_id;
    logic [1:0]      m_op;
    logic [ID_W-1:0] m_id;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clr_cmd = 0; m_clr_id = 0; m_in = 0; m_arr = 0; m_ovf = 0; m_tmo_p = 0;
            m_dest = '0; m_tmo = 0;
            m_q.delete();
        end else begin
            do_cmd = m_clr_cmd;
            do_id  = m_clr_id;
            m_clr_cmd = 0; m_clr_id = 0; m_arr = 0; m_ovf = 0; m_tmo_p = 0;
            if (do_cmd) begin
                m_op = cmd[ID_W+1 -: 2];
                m_id = cmd[ID_W-1:0];
                m_tmo = 0;
                if (m_op == STOP) begin
                    m_q.delete(); m_in = 0;
                end else if (m_op == GO) begin
                    m_q.delete(); m_dest = m_id; m_in = 1;
                end else if (m_op == APP) begin
                    if (!m_in) begin
                        m_dest = m_id; m_in = 1;
                    end else if (m_q.size() < DEPTH) begin
                        m_q.push_back(m_id);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end else if (do_id) begin
                m_tmo = 0;
                if (ID == m_dest) begin
                    m_arr = 1;
                    if (m_q.size() > 0) m_dest = m_q.pop_front();
                    else m_in = 0;
                end
            end else if (m_in) begin
`ifdef CMDCTRL_TIMEOUT_EN
                if (m_tmo == TMO - 1) begin
                    m_q.delete(); m_in = 0; m_tmo_p = 1; m_tmo = 0;
                end else begin
                    m_tmo++;
`endif
                    if (ID_vld) m_clr_id = 1;
                    else if (cmd_rdy) m_clr_cmd = 1;
`ifdef CMDCTRL_TIMEOUT_EN
                end
`endif
            end else begin
                m_tmo = 0;
                if (cmd_rdy) m_clr_cmd = 1;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        check("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(m_clr_cmd));
        check("clr_ID_vld",  32'(clr_ID_vld),  32'(m_clr_id));
        check("in_transit",  32'(in_transit),  32'(m_in));
        check("dest_ID",     32'(dest_ID),     32'(m_dest));
        check("arrived",     32'(arrived),     32'(m_arr));
        check("q_cnt",       32'(q_cnt),       32'(m_q.size()));
        check("q_ovf",       32'(q_ovf),       32'(m_ovf));
`ifdef CMDCTRL_TIMEOUT_EN
        check("timeout",     32'(timeout),     32'(m_tmo_p));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clr_cmd();
        bit got = 0;
        for (int k = 0; k < LIMIT && !got; k++) begin
            @(posedge clk); #1;
            if (clr_cmd_rdy === 1'b1) got = 1;
        end
        if (!got) bound_expired("clr_cmd_rdy_wait");
    endtask

    task automatic wait_clr_id();
        bit got = 0;
        for (int k = 0; k < LIMIT && !got; k++) begin
            @(posedge clk); #1;
            if (clr_ID_vld === 1'b1) got = 1;
        end
        if (!got) bound_expired("clr_ID_vld_wait");
    endtask

    // Returns #1 after the edge that executed the command.
    task automatic send_cmd(input logic [1:0] op, input logic [ID_W-1:0] id);
        cmd = {op, id};
        cmd_rdy = 1'b1;
        wait_clr_cmd();
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
    endtask

    // Returns #1 after the edge that executed the ID check.
    task automatic send_id(input logic [ID_W-1:0] id);
        ID = id;
        ID_vld = 1'b1;
        wait_clr_id();
        @(posedge clk); #1;
        ID_vld = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_transit", 32'(in_transit), 32'd0);
        check("rst_dest_ID",    32'(dest_ID),    32'd0);
        check("rst_q_cnt",      32'(q_cnt),      32'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Basic trip: GO 5, wrong station 3, then station 5.
        send_cmd(GO, 6'd5);
        check("go5_in_transit", 32'(in_transit), 32'd1);
        check("go5_dest",       32'(dest_ID),    32'd5);
        send_id(6'd3);
        check("id3_in_transit", 32'(in_transit), 32'd1);
        check("id3_arrived",    32'(arrived),    32'd0);
        send_id(6'd5);
        check("id5_arrived",    32'(arrived),    32'd1);
        check("id5_in_transit", 32'(in_transit), 32'd0);
        repeat (2) @(posedge clk);

        // Station IDs are ignored while idle.
        #1; ID = 6'd9; ID_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_id_ignored", 32'(clr_ID_vld), 32'd0);
        ID_vld = 1'b0;

        // Waypoints: GO 1, APPEND 2, APPEND 3, then walk the route.
        send_cmd(GO, 6'd1);
        send_cmd(APP, 6'd2);
        send_cmd(APP, 6'd3);
        check("wp_q_cnt2", 32'(q_cnt), 32'd2);
        send_id(6'd1);
        check("wp_dest2",  32'(dest_ID), 32'd2);
        check("wp_q_cnt1", 32'(q_cnt),   32'd1);
        send_id(6'd2);
        check("wp_dest3",  32'(dest_ID), 32'd3);
        send_id(6'd3);
        check("wp_done_transit", 32'(in_transit), 32'd0);
        check("wp_done_q_cnt",   32'(q_cnt),      32'd0);

        // Overflow: GO 1 and five appends; only the fifth is dropped.
        send_cmd(GO, 6'd1);
        for (int i = 0; i < 5; i++) begin
            send_cmd(APP, 6'(10 + i));
            check("ovf_pulse", 32'(q_ovf), (i == 4) ? 32'd1 : 32'd0);
        end
        check("ovf_q_cnt", 32'(q_cnt), 32'd4);
        send_cmd(STOP, 6'd0);
        check("stop_q_cnt",   32'(q_cnt),      32'd0);
        check("stop_transit", 32'(in_transit), 32'd0);

        // Simultaneous ID and command in MOVING: ID check goes first.
        send_cmd(GO, 6'd8);
        send_cmd(APP, 6'd9);
        cmd = {STOP, 6'd0}; cmd_rdy = 1'b1;
        ID = 6'd20; ID_vld = 1'b1;
        wait_clr_id();
        check("order_cmd_not_first", 32'(clr_cmd_rdy), 32'd0);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        check("order_q_cnt1",   32'(q_cnt),      32'd1);
        check("order_dest8",    32'(dest_ID),    32'd8);
        wait_clr_cmd();
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        check("order_stop_q_cnt",   32'(q_cnt),      32'd0);
        check("order_stop_transit", 32'(in_transit), 32'd0);

        // APPEND while idle starts a trip; reserved opcode during transit is inert.
        send_cmd(APP, 6'd6);
        check("app_idle_transit", 32'(in_transit), 32'd1);
        check("app_idle_dest",    32'(dest_ID),    32'd6);
        check("app_idle_q_cnt",   32'(q_cnt),      32'd0);
        send_cmd(RSV, 6'd33);
        check("rsv_moving_transit", 32'(in_transit), 32'd1);
        check("rsv_moving_dest",    32'(dest_ID),    32'd6);
        send_id(6'd6);
        check("app_idle_arrived", 32'(arrived), 32'd1);

        // Asynchronous reset mid-transit with three queued waypoints.
        send_cmd(GO, 6'd1);
        send_cmd(APP, 6'd2);
        send_cmd(APP, 6'd3);
        send_cmd(APP, 6'd4);
        check("pre_rst_q_cnt", 32'(q_cnt), 32'd3);
        #2; rst = 1'b1; #1;
        check("arst_in_transit", 32'(in_transit), 32'd0);
        check("arst_dest_ID",    32'(dest_ID),    32'd0);
        check("arst_q_cnt",      32'(q_cnt),      32'd0);
        check("arst_arrived",    32'(arrived),    32'd0);
        check("arst_q_ovf",      32'(q_ovf),      32'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Reserved opcode while idle: consumed, stays idle.
        send_cmd(RSV, 6'd9);
        check("rsv_idle_transit", 32'(in_transit), 32'd0);
        check("rsv_idle_dest",    32'(dest_ID),    32'd0);
        send_cmd(GO, 6'd2);
        check("after_rsv_go", 32'(in_transit), 32'd1);
        send_id(6'd2);

        // Asynchronous reset in the middle of a command check.
        cmd = {GO, 6'd4}; cmd_rdy = 1'b1;
        wait_clr_cmd();
        #2; rst = 1'b1; #1;
        check("arst_cmdchk_clr", 32'(clr_cmd_rdy), 32'd0);
        cmd_rdy = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("arst_cmdchk_transit", 32'(in_transit), 32'd0);
        check("arst_cmdchk_dest",    32'(dest_ID),    32'd0);

`ifdef CMDCTRL_TIMEOUT_EN
        // Watchdog: GO 7 and never report a station.
        begin
            int  cycles = 0;
            bit  got    = 0;
            send_cmd(GO, 6'd7);
            for (int k = 0; k < 40 && !got; k++) begin
                @(posedge clk); #1;
                cycles++;
                if (timeout === 1'b1) got = 1;
            end
            if (!got) bound_expired("timeout_wait");
            else check("timeout_latency", 32'(cycles), 32'd16);
            check("timeout_transit", 32'(in_transit), 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cmd_route_ctrl
